// File: rtl/ice51_uart_loader.sv
// ice51_uart_loader: receives MEM_SIZE bytes over 8N1 UART and writes them to program memory from address 0.
// A sticky o_load_done marks the end of the load; stop-bit errors pulse o_frame_err.
module ice51_uart_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int MEM_SIZE     = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_load_done,
    output logic              o_frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [CNT_W-1:0]  HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);

    logic              r_rx_meta, r_rx_s;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_mem_we, r_load_done, r_frame_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              w_half, w_full, w_last;

    assign w_half = r_cnt == HALF;
    assign w_full = r_cnt == FULL;
    assign w_last = r_ptr == LAST;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_load_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= i_uart_rx;
            r_rx_s      <= r_rx_meta;
            r_mem_we    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) r_state <= S_START;
                end
                S_START: begin
                    // a line that is high again at mid start bit was only a glitch
                    if (w_half) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_cnt          <= '0;
                        r_shift[r_bit] <= r_rx_s;
                        r_bit          <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_full) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_ptr;
                            r_mem_data <= r_shift;
                            r_ptr      <= w_last ? r_ptr : r_ptr + 1'b1;
                            r_state    <= w_last ? S_DONE : S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                S_DONE: begin
                    r_load_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_load_done = r_load_done;
    assign o_frame_err = r_frame_err;
endmodule

// File: tb/tb_ice51_uart_loader.sv
// tb_ice51_uart_loader: table-driven and randomized checks of the UART program loader against a queue-based model.
module tb_ice51_uart_loader;
    localparam int CPB = 104;
    localparam int MEM = 4;
    localparam int AW  = 9;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_uart_rx;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    o_mem_data;
    logic          o_load_done;
    logic          o_frame_err;

    always #5 i_clk = ~i_clk;

    ice51_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MEM), .ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_uart_rx(i_uart_rx),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_load_done(o_load_done), .o_frame_err(o_frame_err)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { logic [7:0] data; int stop; int cpb; int rst; int we; int addr; int fe; } vec_t;

    wr_t got[$];
    wr_t exp_q[$];
    int  fe_cnt, cyc, last_we_cyc, done_cyc;
    bit  done_seen, done_drop;
    int  checks, errors;
    int  m_ptr, m_fe;
    bit  m_done;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_mem_we === 1'b1) begin
            got.push_back('{int'(o_mem_addr), int'(o_mem_data)});
            last_we_cyc = cyc;
        end
        if (o_frame_err === 1'b1) fe_cnt++;
        if (o_load_done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (done_seen && o_load_done !== 1'b1) done_drop = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst     = 1'b1;
        i_uart_rx = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        got.delete();
        fe_cnt    = 0;
        done_seen = 1'b0;
        done_drop = 1'b0;
        exp_q.delete();
        m_ptr  = 0;
        m_fe   = 0;
        m_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop, input int cpb);
        @(negedge i_clk);
        i_uart_rx = 1'b0;
        idle(cpb);
        for (int b = 0; b < 8; b++) begin
            i_uart_rx = d[b];
            idle(cpb);
        end
        i_uart_rx = stop != 0;
        idle(cpb);
        if (stop == 0) idle(300);
        i_uart_rx = 1'b1;
        idle(cpb);
    endtask

    // reference: every well-framed byte lands at the next address until MEM bytes are stored
    task automatic model_frame(input logic [7:0] d, input int stop);
        if (!m_done) begin
            if (stop != 0) begin
                exp_q.push_back('{m_ptr, int'(d)});
                m_ptr++;
                if (m_ptr == MEM) m_done = 1'b1;
            end else begin
                m_fe++;
            end
        end
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{8'hA5, 1, 104, 1, 1, 0, 0};
        vt[1]  = '{8'h01, 1, 104, 1, 1, 0, 0};
        vt[2]  = '{8'h02, 1, 104, 0, 1, 1, 0};
        vt[3]  = '{8'h03, 1, 104, 0, 1, 2, 0};
        vt[4]  = '{8'h04, 1, 104, 0, 1, 3, 0};
        vt[5]  = '{8'hFF, 1, 104, 0, 0, 0, 0};
        vt[6]  = '{8'h5A, 0, 104, 1, 0, 0, 1};
        vt[7]  = '{8'h11, 1, 104, 0, 1, 0, 0};
        vt[8]  = '{8'h00, 1, 102, 1, 1, 0, 0};
        vt[9]  = '{8'hFF, 1, 102, 0, 1, 1, 0};
        vt[10] = '{8'h55, 1, 102, 0, 1, 2, 0};
        vt[11] = '{8'h00, 1, 106, 1, 1, 0, 0};
        vt[12] = '{8'hFF, 1, 106, 0, 1, 1, 0};
        vt[13] = '{8'h55, 1, 106, 0, 1, 2, 0};

        i_rst     = 1'b1;
        i_uart_rx = 1'b1;
        idle(3);
        i_rst = 1'b0;
        chk("reset we", int'(o_mem_we), 0);
        chk("reset addr", int'(o_mem_addr), 0);
        chk("reset data", int'(o_mem_data), 0);
        chk("reset done", int'(o_load_done), 0);
        chk("reset ferr", int'(o_frame_err), 0);

        for (int i = 0; i < 14; i++) begin
            int n0, f0;
            if (vt[i].rst != 0) do_reset();
            n0 = got.size();
            f0 = fe_cnt;
            send_frame(vt[i].data, vt[i].stop, vt[i].cpb);
            idle(20);
            chk($sformatf("v%0d writes", i), got.size() - n0, vt[i].we);
            if (vt[i].we != 0 && got.size() > n0) begin
                chk($sformatf("v%0d addr", i), got[n0].addr, vt[i].addr);
                chk($sformatf("v%0d data", i), got[n0].data, int'(vt[i].data));
            end
            chk($sformatf("v%0d ferr", i), fe_cnt - f0, vt[i].fe);
            if (i == 0) chk("single byte done", int'(o_load_done), 0);
            if (i == 5) begin
                chk("done held", int'(o_load_done), 1);
                chk("done after last write", done_cyc - last_we_cyc, 1);
                chk("done never dropped", int'(done_drop), 0);
            end
        end

        do_reset();
        @(negedge i_clk);
        i_uart_rx = 1'b0;
        idle(20);
        i_uart_rx = 1'b1;
        idle(300);
        chk("glitch writes", got.size(), 0);
        chk("glitch ferr", fe_cnt, 0);
        send_frame(8'h3C, 1, CPB);
        idle(20);
        chk("after glitch writes", got.size(), 1);
        if (got.size() > 0) begin
            chk("after glitch addr", got[0].addr, 0);
            chk("after glitch data", got[0].data, 8'h3C);
        end

        do_reset();
        send_frame(8'hC3, 1, CPB);
        send_frame(8'h3C, 1, CPB);
        chk("pre-reset writes", got.size(), 2);
        @(negedge i_clk);
        i_uart_rx = 1'b0;
        idle(CPB);
        for (int b = 0; b < 4; b++) begin
            i_uart_rx = b[0];
            idle(CPB);
        end
        i_uart_rx = 1'b1;
        idle(CPB / 2);
        do_reset();
        chk("midreset we", int'(o_mem_we), 0);
        chk("midreset addr", int'(o_mem_addr), 0);
        chk("midreset data", int'(o_mem_data), 0);
        chk("midreset done", int'(o_load_done), 0);
        chk("midreset ferr", int'(o_frame_err), 0);
        idle(CPB * 10);
        chk("midreset stray writes", got.size(), 0);
        send_frame(8'h77, 1, CPB);
        idle(20);
        chk("midreset 0x77 writes", got.size(), 1);
        if (got.size() > 0) begin
            chk("midreset 0x77 addr", got[0].addr, 0);
            chk("midreset 0x77 data", got[0].data, 8'h77);
        end

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                logic [7:0] d;
                int cpb, stop;
                d    = 8'($urandom);
                cpb  = $urandom_range(102, 106);
                stop = ($urandom_range(0, 4) != 0) ? 1 : 0;
                send_frame(d, stop, cpb);
                model_frame(d, stop);
            end
            idle(20);
            chk($sformatf("rand%0d count", r), got.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
                chk($sformatf("rand%0d w%0d addr", r, j), got[j].addr, exp_q[j].addr);
                chk($sformatf("rand%0d w%0d data", r, j), got[j].data, exp_q[j].data);
            end
            chk($sformatf("rand%0d ferr", r), fe_cnt, m_fe);
            chk($sformatf("rand%0d done", r), int'(o_load_done), int'(m_done));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ice51_uart_loader.md
Name: ice51_uart_loader

Overview:
UART-receive program loader inside the ice51 core.
- After reset, receives MEM_SIZE bytes over the serial line at 115200 baud, 8N1, LSB first.
- Writes each byte sequentially into program memory from address 0.
- Asserts a sticky done flag that releases the CPU from reset.
- Sits between the top-level i_uart_rx pin and the program-memory write port.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200)
MEM_SIZE, 512, number of bytes to load before done
ADDR_W, 9, width of memory address (must satisfy 2^ADDR_W >= MEM_SIZE)

Ports:
i_clk  input  1  system clock, 12 MHz
i_rst  input  1  reset; one clock; reset is synchronous and active-high
i_uart_rx  input  1  asynchronous serial input, idle high
o_mem_we  output  1  program-memory write strobe, single-cycle pulse
o_mem_addr  output  ADDR_W  write address
o_mem_data  output  8  write data
o_load_done  output  1  sticky; high once MEM_SIZE bytes are written
o_frame_err  output  1  single-cycle pulse on stop-bit error

Behaviour:
- Reset values (all registers cleared on i_rst at a rising edge):
  - o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_load_done=0, o_frame_err=0.
  - Byte pointer=0, bit counter=0, baud counter=0, state=IDLE.
  - Synchronizer flops=1.
- i_uart_rx passes through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
- State machine:
  - IDLE: rx_s==0 -> START; baud counter cleared.
  - START: count CLKS_PER_BIT/2 cycles (mid start bit).
    - rx_s==1 -> glitch: return to IDLE with no output.
    - Otherwise -> DATA; bit counter=0; baud counter cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[bit counter] (LSB first). After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 -> in the next cycle: o_mem_we=1, o_mem_data=byte, o_mem_addr=pointer, all for exactly one cycle. Pointer increments after the write. Return to IDLE.
    - 0 -> o_frame_err=1 for one cycle; no write; pointer unchanged; -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. This prevents a held-low line being taken as a new start.
  - DONE: entered in the cycle after the write to address MEM_SIZE-1.
    - o_load_done=1 and held until reset.
    - Serial input ignored; o_mem_we and o_frame_err stay 0.
- o_mem_addr and o_mem_data hold their last values between strobes; they are valid only while o_mem_we=1.
- Pointer never wraps: DONE is reached exactly at MEM_SIZE writes.
- Latency: the o_mem_we pulse occurs 1 cycle after the stop-bit mid-sample, which is about 9.5 bit times plus 3 cycles after the falling edge at the pin.
- Tolerance: a sender at CLKS_PER_BIT ±2 cycles/bit must decode correctly.
- Reset mid-byte or mid-load:
  - Partial byte discarded; pointer returns to 0; o_load_done cleared.
  - A line still low after reset is treated as a start bit only after a high-to-low transition. After reset the state is IDLE and the synchronizer holds 1, so a line held low at reset release is seen as a falling edge on the first cycle.
  - The bench releases reset with the line high.
- i_rst has priority over every other event in the same cycle.

Test Plan:
- Single byte 0xA5 at 104 clk/bit after reset -> exactly one o_mem_we pulse with addr=0, data=0xA5; o_frame_err=0; o_load_done=0.
- MEM_SIZE=4; send 0x01,0x02,0x03,0x04 then 0xFF:
  - Writes go to addrs 0..3 with matching data.
  - o_load_done rises in the cycle after the 4th write and stays high.
  - 0xFF produces no write.
- 20-cycle low glitch on i_uart_rx, then idle -> no write, no frame error, pointer still 0. A following 0x3C writes to addr 0.
- Byte 0x5A sent with stop bit=0, line held low 300 cycles, then high:
  - One o_frame_err pulse; no write.
  - Next byte 0x11 is written to addr 0.
- i_rst asserted for 1 cycle during bit 4 of a byte, then 0x77 sent:
  - All outputs at reset values after the reset cycle.
  - 0x77 written to addr 0; no write from the interrupted byte.
- Bytes 0x00, 0xFF, 0x55 sent at 102 and at 106 clk/bit -> all written correctly to consecutive addresses; no frame errors.
